// File: rtl/vga_fb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_ctrl
// Description : 160x120 12-bit frame buffer, 4x up-scaled combinational read
//               for a VGA timing controller, FIFO-fed pixel writes and a
//               whole-buffer colour fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_ctrl #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] d_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_data,
    input  logic        fill_start,
    input  logic [11:0] fill_color,
    output logic        busy,
    output logic        fill_done,
    output logic        drop_err
);

    localparam int c_NPIX = FB_W * FB_H;
    localparam int c_AW   = $clog2(c_NPIX);
    localparam int c_PW   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_EW   = c_AW + 12;

    localparam logic [8:0]      c_ROWS = 9'(FB_H << SCALE_SHIFT);
    localparam logic [9:0]      c_COLS = 10'(FB_W << SCALE_SHIFT);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_NPIX - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_FILL = 1'b1;

    logic [11:0]     r_mem [c_NPIX];
    logic [c_EW-1:0] r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0] r_wp;
    logic [c_PW-1:0] r_rp;
    logic [0:0]      r_state;
    logic [c_AW-1:0] r_cnt;
    logic [11:0]     r_fill_color;
    logic            r_fill_done;
    logic            r_drop_err;

    logic [8:0]      w_rd_row;
    logic [9:0]      w_rd_col;
    logic [c_AW-1:0] w_rd_row_base;
    logic [c_AW-1:0] w_rd_addr;
    logic            w_blank;
    logic            w_empty;
    logic            w_full;
    logic            w_in_range;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [c_AW-1:0] w_wr_addr;
    logic [c_EW-1:0] w_head;
    logic            w_ram_we;
    logic [c_AW-1:0] w_ram_addr;
    logic [11:0]     w_ram_data;

    // Read path: zero latency, the controller registers its own addresses.
    assign w_rd_row = row_addr >> SCALE_SHIFT;
    assign w_rd_col = col_addr >> SCALE_SHIFT;

    generate
        if (FB_W == 160) begin : g_row_x160
            assign w_rd_row_base = (c_AW'(w_rd_row) << 7) + (c_AW'(w_rd_row) << 5);
        end else begin : g_row_xw
            assign w_rd_row_base = c_AW'(w_rd_row) * c_AW'(FB_W);
        end
    endgenerate

    assign w_rd_addr = w_rd_row_base + c_AW'(w_rd_col);
    assign w_blank   = rdn || (row_addr >= c_ROWS) || (col_addr >= c_COLS);
    assign d_out     = w_blank ? 12'h000 : r_mem[w_rd_addr];

    // Extra pointer MSB distinguishes full from empty.
    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[c_PW-1] != r_rp[c_PW-1]) &&
                        (r_wp[c_PW-2:0] == r_rp[c_PW-2:0]);
    assign wr_ready   = !w_full;
    assign w_in_range = ({1'b0, wr_x} < 9'(FB_W)) && ({1'b0, wr_y} < 8'(FB_H));
    assign w_accept   = wr_valid && wr_ready;
    assign w_push     = w_accept && w_in_range;
    assign w_wr_addr  = c_AW'(wr_y) * c_AW'(FB_W) + c_AW'(wr_x);
    assign w_head     = r_fifo[r_rp[c_PW-2:0]];
    assign w_pop      = (r_state == c_ST_IDLE) && !fill_start && !w_empty;

    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_fifo[r_wp[c_PW-2:0]] <= {w_wr_addr, wr_data};
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_accept && !w_in_range) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_fill_color <= 12'h000;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (fill_start) begin
                        r_fill_color <= fill_color;
                        r_cnt        <= '0;
                        r_state      <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (r_cnt == c_LAST) begin
                        r_state     <= c_ST_IDLE;
                        r_fill_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Single RAM write port: the fill owns it, otherwise the FIFO drains.
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = r_cnt;
        w_ram_data = r_fill_color;
        if (r_state == c_ST_FILL) begin
            w_ram_we = 1'b1;
        end else if (w_pop) begin
            w_ram_we   = 1'b1;
            w_ram_addr = w_head[c_EW-1:12];
            w_ram_data = w_head[11:0];
        end
    end

    always_ff @(posedge vga_clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_data;
        end
    end

    assign busy      = (r_state == c_ST_FILL);
    assign fill_done = r_fill_done;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_ctrl
// Description : Self-checking bench for vga_fb_ctrl: read vector table,
//               randomized writes against an image model, fill/FIFO/reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_ctrl;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_out;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [11:0] wr_data;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        busy;
    logic        fill_done;
    logic        drop_err;

    int total = 0;
    int bad   = 0;

    logic [11:0] mdl [19200];

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        rd_n;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [10];

    vga_fb_ctrl dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .rdn        (rdn),
        .d_out      (d_out),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .busy       (busy),
        .fill_done  (fill_done),
        .drop_err   (drop_err)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_rd(input int row, input int col, input logic r);
        if (r || row >= 480 || col >= 640) return 12'h000;
        return mdl[(row / 4) * 160 + (col / 4)];
    endfunction

    task automatic rd_chk(input string nm, input int row, input int col,
                          input logic r, input logic [11:0] exp);
        row_addr = row[8:0];
        col_addr = col[9:0];
        rdn      = r;
        #1;
        chk(nm, {20'b0, d_out}, {20'b0, exp});
    endtask

    // Any of the 4x4 display pixels covering frame-buffer pixel (x,y).
    task automatic rd_px(input string nm, input int x, input int y, input logic [11:0] exp);
        rd_chk(nm, y * 4 + int'($urandom_range(0, 3)), x * 4 + int'($urandom_range(0, 3)), 1'b0, exp);
    endtask

    task automatic write_px(input int x, input int y, input logic [11:0] d);
        int n;
        n = 0;
        wr_x     = x[7:0];
        wr_y     = y[6:0];
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        if (!wr_ready) begin
            bad++;
            total++;
            $display("FAIL write_timeout: got wr_ready=0 expected 1");
        end
        tick();
        wr_valid = 1'b0;
        if (x < 160 && y < 120) mdl[y * 160 + x] = d;
    endtask

    task automatic fill_pulse(input logic [11:0] c);
        fill_color = c;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    task automatic wait_fill_end();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        if (busy) chk("fill_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int row, col;
        logic r;
        logic acc;
        int x, y;

        vecs[0] = '{9'd0,   10'd0,   1'b0, 12'hF00};
        vecs[1] = '{9'd3,   10'd3,   1'b0, 12'hF00};
        vecs[2] = '{9'd2,   10'd1,   1'b0, 12'hF00};
        vecs[3] = '{9'd0,   10'd4,   1'b0, 12'h123};
        vecs[4] = '{9'd3,   10'd7,   1'b0, 12'h123};
        vecs[5] = '{9'd479, 10'd639, 1'b0, 12'h0AB};
        vecs[6] = '{9'd479, 10'd639, 1'b1, 12'h000};
        vecs[7] = '{9'd480, 10'd0,   1'b0, 12'h000};
        vecs[8] = '{9'd0,   10'd640, 1'b0, 12'h000};
        vecs[9] = '{9'd0,   10'd0,   1'b1, 12'h000};

        rst_n = 1'b0; row_addr = '0; col_addr = '0; rdn = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        fill_start = 1'b0; fill_color = '0;
        tick(); tick();
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_fill_done", 32'(fill_done), 32'd0);
        chk("rst_drop_err",  32'(drop_err),  32'd0);
        chk("rst_wr_ready",  32'(wr_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // Basic writes and the read-path vector table
        write_px(0, 0, 12'hF00);
        write_px(1, 0, 12'h123);
        write_px(159, 119, 12'h0AB);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            rd_chk($sformatf("vec%0d", i), int'(vecs[i].row), int'(vecs[i].col),
                   vecs[i].rd_n, vecs[i].exp);
        end

        // Out-of-range write is accepted but discarded
        write_px(0, 6, 12'h777);
        tick(); tick();
        chk("drop_ready_before", 32'(wr_ready), 32'd1);
        write_px(160, 5, 12'hBAD);
        chk("drop_ready_after", 32'(wr_ready), 32'd1);
        tick(); tick(); tick();
        rd_px("drop_ram_unchanged", 0, 6, 12'h777);
        chk("drop_err_set", 32'(drop_err), 32'd1);

        // Full fill, with a second fill_start mid-fill that must be ignored
        fill_pulse(12'h0F0);
        chk("fill_busy_start", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 20000) begin
            n++;
            if (n == 500) begin
                fill_start = 1'b1;
                fill_color = 12'hFFF;
            end else begin
                fill_start = 1'b0;
            end
            tick();
        end
        fill_start = 1'b0;
        chk("fill_cycles", 32'(n), 32'd19200);
        chk("fill_done_pulse", 32'(fill_done), 32'd1);
        tick();
        chk("fill_done_single", 32'(fill_done), 32'd0);
        chk("fill_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 19200; i++) mdl[i] = 12'h0F0;
        rd_px("fill_px_first", 0, 0, 12'h0F0);
        rd_px("fill_px_mid", 80, 60, 12'h0F0);
        rd_px("fill_px_last", 159, 119, 12'h0F0);

        // Randomized writes against the image model
        for (int i = 0; i < 200; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(160, 255)) : int'($urandom_range(0, 159));
            y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 119));
            wr_x    = x[7:0];
            wr_y    = y[6:0];
            wr_data = 12'($urandom);
            acc = wr_valid && wr_ready;
            tick();
            if (acc && x < 160 && y < 120) mdl[y * 160 + x] = wr_data;
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 60; i++) begin
            row = int'($urandom_range(0, 511));
            col = int'($urandom_range(0, 1023));
            r   = ($urandom_range(0, 7) == 0);
            rd_chk($sformatf("rand_rd%0d", i), row, col, r, exp_rd(row, col, r));
        end
        chk("drop_err_sticky", 32'(drop_err), 32'd1);

        // FIFO fills during a fill; drains in order afterwards
        fill_pulse(12'h00F);
        for (int i = 0; i < 19200; i++) mdl[i] = 12'h00F;
        write_px(10, 10, 12'h111);
        write_px(11, 10, 12'h222);
        write_px(10, 10, 12'h333);
        write_px(12, 10, 12'h444);
        chk("fifo_full", 32'(wr_ready), 32'd0);
        wr_x = 8'd13; wr_y = 7'd10; wr_data = 12'h555; wr_valid = 1'b1;
        tick(); tick(); tick();
        chk("fifo_hold", 32'(wr_ready), 32'd0);
        wr_valid = 1'b0;
        wait_fill_end();
        chk("fifo_fill_done", 32'(fill_done), 32'd1);
        chk("fifo_full_at_done", 32'(wr_ready), 32'd0);
        tick();
        chk("fifo_ready_back", 32'(wr_ready), 32'd1);
        rd_px("drain_first", 10, 10, 12'h111);
        tick(); tick();
        rd_px("drain_order", 10, 10, 12'h333);
        tick();
        rd_px("drain_b", 11, 10, 12'h222);
        rd_px("drain_d", 12, 10, 12'h444);
        rd_px("drain_5th_rejected", 13, 10, 12'h00F);

        // Reset clears the sticky error
        rst_n = 1'b0;
        #1;
        chk("rstpulse_drop_err", 32'(drop_err), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstpulse_drop_err_after", 32'(drop_err), 32'd0);

        // Reset in the middle of a fill
        fill_pulse(12'hC0C);
        write_px(100, 100, 12'h999);
        write_px(101, 100, 12'h999);
        write_px(102, 100, 12'h999);
        write_px(103, 100, 12'h999);
        for (int i = 0; i < 996; i++) tick();
        chk("midfill_busy", 32'(busy), 32'd1);
        chk("midfill_full", 32'(wr_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fifo_empty", 32'(wr_ready), 32'd1);
        chk("abort_fill_done", 32'(fill_done), 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        rd_px("abort_fifo_flushed", 100, 100, 12'h00F);
        rd_px("abort_partial_kept", 50, 0, 12'hC0C);
        rd_px("abort_partial_rest", 60, 9, 12'h00F);
        fill_pulse(12'h3C3);
        chk("restart_busy", 32'(busy), 32'd1);
        tick(); tick();
        rd_px("restart_addr0", 0, 0, 12'h3C3);
        rd_px("restart_addr1", 1, 0, 12'h3C3);
        rd_px("restart_not_yet", 50, 0, 12'hC0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
